// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencing controller: walks each instruction through
// fetch/decode/execute/memory/writeback phases over one shared memory port.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [10:0] opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_we,
   output logic        ir_we,
   output logic        mdr_we,
   output logic        reg_we,
   output logic [1:0]  pc_src,
   output logic        reg2loc,
   output logic        alusrc,
   output logic        mem2reg,
   output logic [3:0]  aluctrl,
   output logic [1:0]  signop,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_dsel,
   output logic        retire,
   output logic        halted,
   output logic        error,
   output logic [3:0]  state,
   output logic [31:0] instret
);
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC   = 4'd3,
      S_MEM_RD = 4'd4,
      S_MEM_WR = 4'd5,
      S_WB_ALU = 4'd6,
      S_WB_MEM = 4'd7,
      S_HALT   = 4'd15
   } state_t;

   typedef enum logic [2:0] {
      C_ILL, C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_B
   } class_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
   logic             set_err;
   logic             in_wait;
   class_t           cls;
   logic [3:0]       r_alu;

   // Opcode classification and R-type ALU operation
   always_comb begin
      cls   = C_ILL;
      r_alu = 4'b0010;
      if (opcode == 11'h7C2)           cls = C_LDUR;
      else if (opcode == 11'h7C0)      cls = C_STUR;
      else if (opcode == 11'h458)      cls = C_RTYPE;
      else if (opcode == 11'h658) begin cls = C_RTYPE; r_alu = 4'b0110; end
      else if (opcode == 11'h450) begin cls = C_RTYPE; r_alu = 4'b0000; end
      else if (opcode == 11'h550) begin cls = C_RTYPE; r_alu = 4'b0001; end
      else if (opcode[10:3] == 8'hB4)  cls = C_CBZ;
      else if (opcode[10:5] == 6'h05)  cls = C_B;
   end

   // Next state and per-state control outputs
   always_comb begin
      state_d  = state_q;
      set_err  = 1'b0;
      in_wait  = 1'b0;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      mdr_we   = 1'b0;
      reg_we   = 1'b0;
      pc_src   = 2'd0;
      reg2loc  = 1'b0;
      alusrc   = 1'b0;
      mem2reg  = 1'b0;
      aluctrl  = 4'b0000;
      signop   = 2'b00;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_dsel = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;

      if (state_q inside {S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_MEM}) begin
         case (cls)
            C_RTYPE: aluctrl = r_alu;
            C_LDUR, C_STUR: begin
               alusrc  = 1'b1;
               aluctrl = 4'b0010;
               signop  = 2'b01;
               reg2loc = 1'b1;
            end
            C_CBZ: begin
               aluctrl = 4'b0111;
               signop  = 2'b11;
               reg2loc = 1'b1;
            end
            C_B:     signop = 2'b10;
            default: ;
         endcase
      end

      case (state_q)
         S_INIT: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            in_wait = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (cls == C_ILL) begin
               state_d = S_HALT;
               set_err = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls)
               C_RTYPE: state_d = S_WB_ALU;
               C_LDUR:  state_d = S_MEM_RD;
               C_STUR:  state_d = S_MEM_WR;
               C_CBZ: begin
                  pc_we   = 1'b1;
                  pc_src  = {1'b0, zero};
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               C_B: begin
                  pc_we   = 1'b1;
                  pc_src  = 2'd1;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  state_d = S_HALT;
                  set_err = 1'b1;
               end
            endcase
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_dsel = 1'b1;
            in_wait  = 1'b1;
            if (mem_ready) begin
               mdr_we  = 1'b1;
               state_d = S_WB_MEM;
            end
         end
         S_MEM_WR: begin
            mem_req  = 1'b1;
            mem_dsel = 1'b1;
            mem_we   = 1'b1;
            in_wait  = 1'b1;
            if (mem_ready) begin
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WB_ALU: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_WB_MEM: begin
            reg_we  = 1'b1;
            mem2reg = 1'b1;
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: halted = 1'b1;
         default: begin
            state_d = S_HALT;
            set_err = 1'b1;
         end
      endcase

      // A ready in the last allowed cycle still completes the request
      if (in_wait && !mem_ready && wait_cnt == CNT_LAST) begin
         state_d = S_HALT;
         set_err = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q  <= S_INIT;
         wait_cnt <= '0;
         instret  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (in_wait && !mem_ready)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (retire)
            instret <= instret + 32'd1;
         if (set_err)
            err_q <= 1'b1;
      end
   end

   assign error = err_q;
   assign state = state_q;

endmodule
